align_pipe_nlane: RTL and testbench



---
 rtl/align_pipe_nlane.sv | 155 +++++++++++++++
 tb/tb_align_pipe_nlane.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/align_pipe_nlane.sv
// Two-stage multi-lane exponent aligner: S1 registers the beat and its alignment exponent,
// S2 shifts each lane to that exponent, applies sign and records sticky/flush information.
module align_pipe_nlane #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned MANT_W = 3,
  parameter int unsigned EXP_W  = 6,
  parameter int unsigned OUT_W  = 14,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic                         i_mode,
  input  logic [LANES*(MANT_W+1)-1:0]  i_pp,
  input  logic [LANES*EXP_W-1:0]       i_exp,
  input  logic [EXP_W-1:0]             i_max_exp,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [LANES*(OUT_W+1)-1:0]   o_pp,
  output logic [LANES-1:0]             o_sticky,
  output logic [EXP_W-1:0]             o_max_exp,
  output logic                         o_exp_err,
  input  logic                         i_cnt_clr,
  output logic [CNT_W-1:0]             o_flush_cnt
);

  localparam int unsigned PpW  = MANT_W + 1;
  localparam int unsigned OpW  = OUT_W + 1;
  localparam int unsigned NumW = $clog2(LANES + 1);
  localparam int unsigned SumW = CNT_W + NumW;

  logic                    s1_valid_q, s1_mode_q;
  logic [LANES*PpW-1:0]    s1_pp_q;
  logic [LANES*EXP_W-1:0]  s1_exp_q;
  logic [EXP_W-1:0]        s1_align_q, align_d;

  logic                    out_valid_q, out_err_q;
  logic [LANES*OpW-1:0]    out_pp_q;
  logic [LANES-1:0]        out_sticky_q;
  logic [EXP_W-1:0]        out_max_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    s2_adv, accept, advance;
  logic [LANES*OpW-1:0]    pp_d;
  logic [LANES-1:0]        sticky_d;
  logic                    err_d;
  logic [NumW-1:0]         n_flush;

  logic [MANT_W-1:0]       mant;
  logic [EXP_W-1:0]        lane_exp, diff;
  logic [OUT_W-1:0]        field, mag;
  logic [OpW-1:0]          lane_val;
  logic [SumW-1:0]         sum;

  assign s2_adv     = !out_valid_q || i_out_ready;
  assign o_in_ready = !s1_valid_q || s2_adv;
  assign accept     = i_in_valid && o_in_ready;
  assign advance    = s1_valid_q && s2_adv;

  // Max exponent over nonzero lanes; all-zero beat aligns to 0.
  always_comb begin
    align_d = '0;
    if (i_mode) begin
      align_d = i_max_exp;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (|i_pp[k*PpW +: MANT_W] && (i_exp[k*EXP_W +: EXP_W] > align_d)) begin
          align_d = i_exp[k*EXP_W +: EXP_W];
        end
      end
    end
  end

  always_comb begin
    pp_d     = '0;
    sticky_d = '0;
    err_d    = 1'b0;
    n_flush  = '0;
    mant     = '0;
    lane_exp = '0;
    diff     = '0;
    field    = '0;
    mag      = '0;
    lane_val = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      mant     = s1_pp_q[k*PpW +: MANT_W];
      lane_exp = s1_exp_q[k*EXP_W +: EXP_W];
      diff     = s1_align_q - lane_exp;
      if (s1_mode_q && (lane_exp > s1_align_q)) begin
        diff = '0;
        if (|mant) err_d = 1'b1;
      end
      field = {mant, {(OUT_W-MANT_W){1'b0}}};
      mag   = (32'(diff) >= OUT_W) ? '0 : (field >> diff);
      for (int unsigned j = 0; j < OUT_W; j++) begin
        if (j < 32'(diff)) sticky_d[k] = sticky_d[k] | field[j];
      end
      lane_val = {1'b0, mag};
      if (s1_pp_q[k*PpW + MANT_W]) lane_val = OpW'(0) - lane_val;
      pp_d[k*OpW +: OpW] = lane_val;
      if ((|mant) && (mag == '0)) n_flush = n_flush + NumW'(1);
    end
  end

  always_comb begin
    sum   = SumW'(cnt_q) + SumW'(n_flush);
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = (|sum[SumW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_pp_q      <= '0;
      s1_exp_q     <= '0;
      s1_align_q   <= '0;
      out_valid_q  <= 1'b0;
      out_pp_q     <= '0;
      out_sticky_q <= '0;
      out_max_q    <= '0;
      out_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (o_in_ready) s1_valid_q <= i_in_valid;
      if (accept) begin
        s1_mode_q  <= i_mode;
        s1_pp_q    <= i_pp;
        s1_exp_q   <= i_exp;
        s1_align_q <= align_d;
      end
      if (s2_adv) out_valid_q <= s1_valid_q;
      if (advance) begin
        out_pp_q     <= pp_d;
        out_sticky_q <= sticky_d;
        out_max_q    <= s1_align_q;
        out_err_q    <= err_d;
      end
      cnt_q <= cnt_d;
    end
  end

  assign o_out_valid = out_valid_q;
  assign o_pp        = out_pp_q;
  assign o_sticky    = out_sticky_q;
  assign o_max_exp   = out_max_q;
  assign o_exp_err   = out_err_q;
  assign o_flush_cnt = cnt_q;

endmodule

// File: tb/tb_align_pipe_nlane.sv
// Directed bench for align_pipe_nlane; a second instance with a 2-bit counter covers saturation.
module tb_align_pipe_nlane;
  localparam int LANES = 4;
  localparam int MANT_W = 3;
  localparam int EXP_W = 6;
  localparam int OUT_W = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, mode, out_ready, cnt_clr;
  logic [15:0] pp_in;
  logic [23:0] exp_in;
  logic [5:0]  max_exp_in;
  logic        in_ready, out_valid, exp_err;
  logic [59:0] pp_out;
  logic [3:0]  sticky;
  logic [5:0]  max_exp_out;
  logic [15:0] flush_cnt;
  logic        in_ready2, out_valid2, exp_err2;
  logic [59:0] pp_out2;
  logic [3:0]  sticky2;
  logic [5:0]  max_exp_out2;
  logic [1:0]  flush_cnt2;

  int checks = 0;
  int failures = 0;

  align_pipe_nlane dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_mode(mode), .i_pp(pp_in), .i_exp(exp_in), .i_max_exp(max_exp_in),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_pp(pp_out), .o_sticky(sticky),
    .o_max_exp(max_exp_out), .o_exp_err(exp_err), .i_cnt_clr(cnt_clr),
    .o_flush_cnt(flush_cnt)
  );

  align_pipe_nlane #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready2),
    .i_mode(mode), .i_pp(pp_in), .i_exp(exp_in), .i_max_exp(max_exp_in),
    .o_out_valid(out_valid2), .i_out_ready(out_ready), .o_pp(pp_out2), .o_sticky(sticky2),
    .o_max_exp(max_exp_out2), .o_exp_err(exp_err2), .i_cnt_clr(cnt_clr),
    .o_flush_cnt(flush_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [3:0] pp, input logic [5:0] e);
    pp_in[k*4 +: 4]  = pp;
    exp_in[k*6 +: 6] = e;
  endtask

  function automatic logic [14:0] lane(input int k);
    return pp_out[k*15 +: 15];
  endfunction

  function automatic logic [14:0] signed_val(input logic s, input logic [13:0] mag);
    logic [14:0] v;
    v = {1'b0, mag};
    return s ? (15'd0 - v) : v;
  endfunction

  function automatic logic [20:0] beat_exp(input int i);
    logic [2:0] m;
    m = 3'(4 + (i % 4));
    return {6'(i + 1), signed_val(i[0], {m, 11'b0})};
  endfunction

  task automatic drive_beat(input int i);
    logic [2:0] m;
    m = 3'(4 + (i % 4));
    mode = 1'b0;
    pp_in = '0;
    exp_in = '0;
    set_lane(0, {i[0], m}, 6'(i + 1));
  endtask

  task automatic load_test1();
    mode = 1'b0;
    max_exp_in = '0;
    set_lane(0, 4'b0111, 6'd10);
    set_lane(1, 4'b1100, 6'd8);
    set_lane(2, 4'b1000, 6'd63);
    set_lane(3, 4'b1000, 6'd63);
  endtask

  task automatic load_flush();
    mode = 1'b1;
    max_exp_in = 6'd63;
    for (int k = 0; k < 4; k++) set_lane(k, 4'b0001, 6'd0);
  endtask

  logic        held;
  logic [20:0] held_v;
  int          acc, dlv;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    pp_in = '0; exp_in = '0; max_exp_in = '0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pp", pp_out, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_max_exp", max_exp_out, 0);
    chk("rst_exp_err", exp_err, 0);
    chk("rst_cnt", flush_cnt, 0);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // Mode 0: max over nonzero lanes, sign conversion
    load_test1();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_latency1", out_valid, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_max_exp", max_exp_out, 10);
    chk("t1_l0", lane(0), 15'h3800);
    chk("t1_l1", lane(1), 15'h7800);
    chk("t1_l2", lane(2), 0);
    chk("t1_l3", lane(3), 0);
    chk("t1_sticky", sticky, 0);
    chk("t1_cnt", flush_cnt, 0);

    // Partial shift-out with sticky
    mode = 1'b1;
    max_exp_in = 6'd20;
    set_lane(0, 4'b0101, 6'd8);
    set_lane(1, 4'b0101, 6'd7);
    set_lane(2, 4'b0101, 6'd0);
    set_lane(3, 4'b0101, 6'd9);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t2_valid", out_valid, 1);
    chk("t2_l0", lane(0), 2);
    chk("t2_l1", lane(1), 1);
    chk("t2_l2", lane(2), 0);
    chk("t2_l3", lane(3), 5);
    chk("t2_sticky", sticky, 4'b0111);
    chk("t2_max_exp", max_exp_out, 20);
    chk("t2_exp_err", exp_err, 0);
    chk("t2_cnt", flush_cnt, 1);

    // Mode 1 exponent violation
    max_exp_in = 6'd5;
    set_lane(0, 4'b0100, 6'd7);
    set_lane(1, 4'b1110, 6'd3);
    set_lane(2, 4'b0000, 6'd0);
    set_lane(3, 4'b1000, 6'd60);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t3_l0", lane(0), 15'h2000);
    chk("t3_l1", lane(1), 15'h7400);
    chk("t3_l3", lane(3), 0);
    chk("t3_exp_err", exp_err, 1);
    chk("t3_sticky", sticky, 0);
    chk("t3_cnt", flush_cnt, 1);

    // Full flush beats: 4 lanes each, small counter saturates
    load_flush();
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("t4_cnt_a", flush_cnt, 5);
    chk("t4_sat_a", flush_cnt2, 3);
    chk("t4_sticky", sticky, 4'hF);
    chk("t4_pp", pp_out, 0);
    step();
    chk("t4_cnt_b", flush_cnt, 9);
    chk("t4_sat_b", flush_cnt2, 3);

    // Clear coincides with a flush beat advancing
    step();
    load_flush();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t5_valid", out_valid, 1);
    chk("t5_cnt", flush_cnt, 0);
    chk("t5_cnt2", flush_cnt2, 0);
    step();
    chk("t5_cnt_idle", flush_cnt, 0);

    // Backpressure stream
    step();
    held = 1'b0;
    held_v = '0;
    acc = 0;
    dlv = 0;
    for (int c = 0; c < 80 && dlv < 10; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      in_valid = (acc < 10);
      if (acc < 10) drive_beat(acc);
      #1;
      if (held) chk("bp_hold", {out_valid, max_exp_out, lane(0)}, {1'b1, held_v});
      chk("bp_in_ready", in_ready, ((acc - dlv) == 2 && !out_ready) ? 0 : 1);
      held = out_valid && !out_ready;
      held_v = {max_exp_out, lane(0)};
      if (out_valid && out_ready) begin
        chk("bp_data", {max_exp_out, lane(0)}, beat_exp(dlv));
        dlv++;
      end
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_delivered", dlv, 10);
    chk("bp_accepted", acc, 10);
    step();
    step();

    // Reset with two beats in flight
    out_ready = 1'b0;
    load_test1();
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("t7_full_ready", in_ready, 0);
    rst_n = 1'b0;
    step();
    chk("t7_valid", out_valid, 0);
    chk("t7_pp", pp_out, 0);
    chk("t7_max_exp", max_exp_out, 0);
    chk("t7_in_ready", in_ready, 1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("t7_no_ghost", out_valid, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t7_latency1", out_valid, 0);
    step();
    chk("t7_fresh_valid", out_valid, 1);
    chk("t7_fresh_l1", lane(1), 15'h7800);
    chk("t7_fresh_max", max_exp_out, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
